// File: rtl/ctrl_spi_slave.sv
// ctrl_spi_slave: SPI (mode 0) slave that snapshots the receiver channel set on
// each ch_data_rdy and shifts {status, channels N-1..0} out MSB-first on miso.
// The SPI pins are oversampled in the clk_system domain.
// Ports:
//   clk_system, reset      - system clock, asynchronous active-high reset
//   ch_data, ch_data_rdy   - channel bus (channel 0 in LSBs) and its one-cycle strobe
//   sck, mosi, slave_select_n - SPI pins from the host (asynchronous)
//   miso                   - SPI data to host (registered, 0 outside ACTIVE)
//   frame_done             - one-cycle pulse after a complete frame
//   overrun                - sticky, a receiver update was dropped
module ctrl_spi_slave #(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned CHANNEL_WIDTH = 16
) (
    input  logic                                  clk_system,
    input  logic                                  reset,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] ch_data,
    input  logic                                  ch_data_rdy,
    input  logic                                  sck,
    input  logic                                  mosi,
    input  logic                                  slave_select_n,
    output logic                                  miso,
    output logic                                  frame_done,
    output logic                                  overrun
);
    localparam int unsigned DATA_W  = NUM_CHANNELS * CHANNEL_WIDTH;
    localparam int unsigned FRAME_W = 8 + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TAIL   = 2'd2
    } state_t;

    state_t              state;
    logic                sck_meta, sck_sync, sck_prev;
    logic                mosi_meta, mosi_sync;
    logic                ss_meta, ss_sync, ss_prev;
    logic [DATA_W-1:0]   snap, pend;
    logic                pend_valid;
    logic                new_flag;
    logic [3:0]          seq;
    logic [FRAME_W-1:0]  tx;
    logic [CNT_W-1:0]    bit_cnt;
    logic [7:0]          cmd;

    logic                sck_rise, sck_fall, ss_rise, ss_fall;
    logic                snap_load, pend_load, drop;
    logic [DATA_W-1:0]   snap_src, snap_next;
    logic [3:0]          seq_next;
    logic                new_flag_next;
    logic [7:0]          status;
    logic                unused_cmd;

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;
    assign ss_rise  = ss_sync & ~ss_prev;
    assign ss_fall  = ~ss_sync & ss_prev;

    // Only the last command bit acts on anything; the upper bits are kept for visibility.
    assign unused_cmd = ^cmd[7:1];

    // Decide where a receiver strobe lands and what the snapshot becomes this cycle.
    // A strobe coinciding with select rise is newer than pend, so it wins and pend is dropped.
    always_comb begin
        snap_load = 1'b0;
        pend_load = 1'b0;
        drop      = 1'b0;
        snap_src  = ch_data;
        if (state == IDLE) begin
            snap_load = ch_data_rdy;
        end else if (ss_rise) begin
            if (ch_data_rdy) begin
                snap_load = 1'b1;
                drop      = pend_valid;
            end else if (pend_valid) begin
                snap_load = 1'b1;
                snap_src  = pend;
            end
        end else if (ch_data_rdy) begin
            pend_load = 1'b1;
            drop      = pend_valid;
        end
        snap_next     = snap_load ? snap_src : snap;
        seq_next      = snap_load ? seq + 4'd1 : seq;
        new_flag_next = snap_load | new_flag;
        status        = {new_flag_next, overrun, 2'b00, seq_next};
    end

    // Synchronizers, snapshot bookkeeping and frame FSM.
    always_ff @(posedge clk_system or posedge reset) begin
        if (reset) begin
            sck_meta   <= 1'b0;
            sck_sync   <= 1'b0;
            sck_prev   <= 1'b0;
            mosi_meta  <= 1'b0;
            mosi_sync  <= 1'b0;
            ss_meta    <= 1'b1;
            ss_sync    <= 1'b1;
            ss_prev    <= 1'b1;
            state      <= IDLE;
            snap       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            new_flag   <= 1'b0;
            seq        <= 4'd0;
            tx         <= '0;
            bit_cnt    <= '0;
            cmd        <= 8'h00;
            miso       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sck_meta   <= sck;
            sck_sync   <= sck_meta;
            sck_prev   <= sck_sync;
            mosi_meta  <= mosi;
            mosi_sync  <= mosi_meta;
            ss_meta    <= slave_select_n;
            ss_sync    <= ss_meta;
            ss_prev    <= ss_sync;

            frame_done <= 1'b0;
            snap       <= snap_next;
            seq        <= seq_next;
            new_flag   <= new_flag_next;
            if (pend_load) begin
                pend       <= ch_data;
                pend_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (ss_fall) begin
                        tx      <= {status, snap_next};
                        bit_cnt <= '0;
                        cmd     <= 8'h00;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    miso <= tx[FRAME_W-1];
                    if (ss_rise) begin
                        // Short frame: abort without touching the flags.
                        pend_valid <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt < CNT_W'(8)) begin
                                cmd <= {cmd[6:0], mosi_sync};
                            end
                            if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                                state <= TAIL;
                            end
                        end
                        if (sck_fall) begin
                            tx <= {tx[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                TAIL: begin
                    miso <= 1'b0;
                    if (ss_rise) begin
                        frame_done <= 1'b1;
                        // A snapshot load in the same cycle keeps new_flag set.
                        new_flag   <= snap_load;
                        if (cmd[0]) begin
                            overrun <= 1'b0;
                        end
                        pend_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    miso  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Dropping an update outranks a host clear in the same cycle.
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ctrl_spi_slave.sv
`timescale 1ns/1ps
module tb_ctrl_spi_slave;
    localparam int unsigned FW = 72;

    logic        clk_system = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] ch_data = '0;
    logic        ch_data_rdy = 1'b0;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        slave_select_n = 1'b1;
    logic        miso;
    logic        frame_done;
    logic        overrun;

    ctrl_spi_slave #(.NUM_CHANNELS(4), .CHANNEL_WIDTH(16)) dut (
        .clk_system     (clk_system),
        .reset          (reset),
        .ch_data        (ch_data),
        .ch_data_rdy    (ch_data_rdy),
        .sck            (sck),
        .mosi           (mosi),
        .slave_select_n (slave_select_n),
        .miso           (miso),
        .frame_done     (frame_done),
        .overrun        (overrun)
    );

    always #5 clk_system = ~clk_system;

    typedef struct {
        logic        reset_before;
        logic        pre_strobe;
        logic [63:0] pre_val;
        logic        strobe_at_fall;
        logic [7:0]  cmd;
        int          nbits;
        int          mid_strobes;
        logic [63:0] mid_a;
        logic [63:0] mid_b;
        logic [7:0]  exp_status;
        logic [63:0] exp_data;
        int          exp_done;
        logic        exp_ovr;
    } frame_t;

    int     errors = 0;
    int     checks = 0;
    int     done_cnt = 0;
    logic   exp_q[$];
    frame_t tbl[9];

    always @(negedge clk_system) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_system);
        #1;
    endtask

    task automatic strobe(input logic [63:0] v);
        ch_data     = v;
        ch_data_rdy = 1'b1;
        tick(1);
        ch_data_rdy = 1'b0;
    endtask

    function automatic frame_t mk(input logic rb, input logic ps, input logic [63:0] pv,
                                  input logic saf, input logic [7:0] c, input int nb,
                                  input int ms, input logic [63:0] a, input logic [63:0] b,
                                  input logic [7:0] st, input logic [63:0] d,
                                  input int dn, input logic ov);
        frame_t f;
        f.reset_before = rb;  f.pre_strobe = ps;  f.pre_val = pv;
        f.strobe_at_fall = saf; f.cmd = c; f.nbits = nb; f.mid_strobes = ms;
        f.mid_a = a; f.mid_b = b; f.exp_status = st; f.exp_data = d;
        f.exp_done = dn; f.exp_ovr = ov;
        return f;
    endfunction

    // Host-side frame: expected miso bits are queued up front and popped as each bit is sampled.
    task automatic run_frame(input frame_t f, input int idx);
        logic [FW-1:0] exp_vec;
        logic [7:0]    c;
        int            d0;
        logic          e;
        exp_vec = {f.exp_status, f.exp_data};
        for (int i = 0; i < f.nbits; i++)
            exp_q.push_back(i < int'(FW) ? exp_vec[FW-1-i] : 1'b0);
        d0 = done_cnt;
        slave_select_n = 1'b0;
        mosi = f.cmd[7];
        if (f.strobe_at_fall) begin
            // Strobe lands on the same cycle the synchronized select fall is acted on.
            tick(2);
            strobe(f.pre_val);
            tick(3);
        end else begin
            tick(6);
        end
        for (int i = 0; i < f.nbits; i++) begin
            e = exp_q.pop_front();
            check($sformatf("frame%0d miso bit%0d", idx, i), {63'd0, miso}, {63'd0, e});
            sck = 1'b1;
            tick(6);
            if (f.mid_strobes >= 1 && i == 10) strobe(f.mid_a);
            if (f.mid_strobes >= 2 && i == 40) strobe(f.mid_b);
            sck = 1'b0;
            c = f.cmd << (i + 1);
            mosi = c[7];
            tick(6);
        end
        slave_select_n = 1'b1;
        mosi = 1'b0;
        tick(10);
        check($sformatf("frame%0d frame_done pulses", idx), 64'(done_cnt - d0), 64'(f.exp_done));
        check($sformatf("frame%0d overrun", idx), {63'd0, overrun}, {63'd0, f.exp_ovr});
    endtask

    // Reset in the middle of a frame, with overrun set beforehand so the clear is visible.
    task automatic reset_mid_frame();
        slave_select_n = 1'b0;
        tick(6);
        for (int i = 0; i < 30; i++) begin
            sck = 1'b1;
            tick(6);
            if (i == 5)  strobe(64'h5555_5555_5555_5555);
            if (i == 12) strobe(64'h6666_6666_6666_6666);
            sck = 1'b0;
            tick(6);
        end
        check("overrun before mid-frame reset", {63'd0, overrun}, 64'd1);
        sck = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        check("mid-frame reset miso", {63'd0, miso}, 64'd0);
        check("mid-frame reset frame_done", {63'd0, frame_done}, 64'd0);
        check("mid-frame reset overrun", {63'd0, overrun}, 64'd0);
        slave_select_n = 1'b1;
        sck = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(6);
    endtask

    initial begin
        logic [63:0] v1, va, vb, vc, vd;
        v1 = 64'h1111_2222_3333_4444;
        va = 64'hAAAA_BBBB_CCCC_DDDD;
        vb = 64'h0123_4567_89AB_CDEF;
        vc = 64'hDEAD_BEEF_CAFE_F00D;
        vd = 64'h8001_7FFE_00FF_FF00;
        //             rb  ps  pv   saf cmd    nb  ms  a   b   status  data  dn ov
        tbl[0] = mk(1'b0, 1'b0, 64'd0, 1'b0, 8'h00, 72, 0, 64'd0, 64'd0, 8'h00, 64'd0, 1, 1'b0);
        tbl[1] = mk(1'b0, 1'b1, v1,    1'b0, 8'h00, 72, 0, 64'd0, 64'd0, 8'h81, v1,    1, 1'b0);
        tbl[2] = mk(1'b0, 1'b0, 64'd0, 1'b0, 8'h00, 72, 2, va,    vb,    8'h01, v1,    1, 1'b1);
        tbl[3] = mk(1'b0, 1'b0, 64'd0, 1'b0, 8'h01, 72, 0, 64'd0, 64'd0, 8'hC2, vb,    1, 1'b0);
        tbl[4] = mk(1'b0, 1'b0, 64'd0, 1'b0, 8'h00, 72, 0, 64'd0, 64'd0, 8'h02, vb,    1, 1'b0);
        tbl[5] = mk(1'b0, 1'b1, vc,    1'b0, 8'h00, 20, 0, 64'd0, 64'd0, 8'h83, vc,    0, 1'b0);
        tbl[6] = mk(1'b0, 1'b0, 64'd0, 1'b0, 8'h00, 80, 0, 64'd0, 64'd0, 8'h83, vc,    1, 1'b0);
        tbl[7] = mk(1'b1, 1'b0, 64'd0, 1'b0, 8'h00, 72, 0, 64'd0, 64'd0, 8'h00, 64'd0, 1, 1'b0);
        tbl[8] = mk(1'b0, 1'b1, vd,    1'b1, 8'h00, 72, 0, 64'd0, 64'd0, 8'h81, vd,    1, 1'b0);

        tick(3);
        check("reset miso", {63'd0, miso}, 64'd0);
        check("reset frame_done", {63'd0, frame_done}, 64'd0);
        check("reset overrun", {63'd0, overrun}, 64'd0);
        reset = 1'b0;
        tick(5);

        for (int k = 0; k < 9; k++) begin
            if (tbl[k].reset_before) reset_mid_frame();
            if (tbl[k].pre_strobe && !tbl[k].strobe_at_fall) begin
                strobe(tbl[k].pre_val);
                tick(2);
            end
            run_frame(tbl[k], k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
